// File: rtl/spart_pkg.sv
// spart_pkg: state type, bus address map and baud divisor table for the
// SPART bus-master controller.
`default_nettype none

package spart_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CFG_LO   = 3'd1,
        CFG_HI   = 3'd2,
        POLL_RX  = 3'd3,
        RX_READ  = 3'd4,
        POLL_TX  = 3'd5,
        TX_WRITE = 3'd6
    } drv_state_t;

    localparam logic [1:0] IOADDR_DATA   = 2'b00;
    localparam logic [1:0] IOADDR_STATUS = 2'b01;
    localparam logic [1:0] IOADDR_DBL    = 2'b10;
    localparam logic [1:0] IOADDR_DBH    = 2'b11;

    localparam logic [15:0] DIV_4800  = 16'h0515;
    localparam logic [15:0] DIV_9600  = 16'h028A;
    localparam logic [15:0] DIV_19200 = 16'h0145;
    localparam logic [15:0] DIV_38400 = 16'h00A2;

    function automatic logic [15:0] baud_div(input logic [1:0] br_cfg);
        logic [15:0] div;
        case (br_cfg)
            2'b00:   div = DIV_4800;
            2'b01:   div = DIV_9600;
            2'b10:   div = DIV_19200;
            default: div = DIV_38400;
        endcase
        return div;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spart_driver_if.sv
// spart_driver_if: SPART bus control strobes (chip select, direction, address)
// shared between the bus master and the SPART.
`default_nettype none

interface spart_driver_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;

    modport master (output iocs, iorw, ioaddr);
    modport slave  (input  iocs, iorw, ioaddr);
endinterface

`default_nettype wire

// File: rtl/spart_driver.sv
// spart_driver: programs the SPART baud divisor after reset, then runs a polled
// RX->TX echo loop. Optional macro SPART_DRIVER_RECONFIG_EN reprograms on br_cfg change.
`default_nettype none

module spart_driver
    import spart_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic [1:0]  br_cfg,
    spart_driver_if.master   bus,
    inout  wire       [7:0]  databus,
    output logic      [7:0]  echo_byte,
    output logic             echo_vld
);

    drv_state_t  state_q, state_d;
    logic [1:0]  cfg_q, cfg_d;
    logic [7:0]  echo_q, echo_d;

    logic        cs;
    logic        rw;
    logic [1:0]  addr;
    logic [7:0]  wdata;
    logic [15:0] div;

    assign div = baud_div(cfg_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cfg_q   <= 2'b00;
            echo_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            echo_q  <= echo_d;
        end
    end

    // Bus strobes are a pure decode of the current state: one access per state.
    always_comb begin
        state_d  = state_q;
        cfg_d    = cfg_q;
        echo_d   = echo_q;
        cs       = 1'b0;
        rw       = 1'b1;
        addr     = IOADDR_DATA;
        wdata    = 8'h00;
        echo_vld = 1'b0;

        case (state_q)
            IDLE: begin
                cfg_d   = br_cfg;
                state_d = CFG_LO;
            end
            CFG_LO: begin
                cs      = 1'b1;
                rw      = 1'b0;
                addr    = IOADDR_DBL;
                wdata   = div[7:0];
                state_d = CFG_HI;
            end
            CFG_HI: begin
                cs      = 1'b1;
                rw      = 1'b0;
                addr    = IOADDR_DBH;
                wdata   = div[15:8];
                state_d = POLL_RX;
            end
            POLL_RX: begin
                cs   = 1'b1;
                addr = IOADDR_STATUS;
`ifdef SPART_DRIVER_RECONFIG_EN
                // A baud change outranks a waiting byte; RDA stays set in the SPART.
                if (br_cfg != cfg_q) begin
                    state_d = IDLE;
                end else if (databus[0]) begin
                    state_d = RX_READ;
                end
`else
                if (databus[0]) begin
                    state_d = RX_READ;
                end
`endif
            end
            RX_READ: begin
                cs      = 1'b1;
                addr    = IOADDR_DATA;
                echo_d  = databus;
                state_d = POLL_TX;
            end
            POLL_TX: begin
                cs   = 1'b1;
                addr = IOADDR_STATUS;
                if (databus[1]) begin
                    state_d = TX_WRITE;
                end
            end
            TX_WRITE: begin
                cs       = 1'b1;
                rw       = 1'b0;
                addr     = IOADDR_DATA;
                wdata    = echo_q;
                echo_vld = 1'b1;
                state_d  = POLL_RX;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.iocs   = cs;
    assign bus.iorw   = rw;
    assign bus.ioaddr = addr;
    assign echo_byte  = echo_q;

    assign databus = (cs && !rw) ? wdata : 8'hZZ;

endmodule

`default_nettype wire

// File: tb/tb_spart_driver.sv
// tb_spart_driver: SPART status/data model plus a bus transaction log; each task
// checks the logged accesses against sequences derived from the divisor table.
`default_nettype none

module tb_spart_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] br_cfg = 2'b00;
    wire  [7:0] databus;
    logic [7:0] echo_byte;
    logic       echo_vld;

    spart_driver_if bus ();

    spart_driver dut (
        .clk       (clk),
        .rst       (rst),
        .br_cfg    (br_cfg),
        .bus       (bus),
        .databus   (databus),
        .echo_byte (echo_byte),
        .echo_vld  (echo_vld)
    );

    always #5 clk = ~clk;

    // Divisor per baud select, indexed by br_cfg.
    logic [15:0] div_tab [4] = '{16'h0515, 16'h028A, 16'h0145, 16'h00A2};

    // SPART model: status = {junk, TBR, RDA}; data = rx_data.
    logic       rda = 1'b0;
    logic       tbr = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [5:0] status_junk = 6'h00;
    logic [7:0] spart_rd;

    always_comb spart_rd = (bus.ioaddr == 2'b01) ? {status_junk, tbr, rda} : rx_data;
    assign databus = (bus.iocs && bus.iorw) ? spart_rd : 8'hzz;

    typedef struct {
        int         cyc;
        logic       rw;
        logic [1:0] addr;
        logic [7:0] data;
        logic       vld;
    } xact_t;

    xact_t obs_q [$];
    xact_t mon_t;
    int    cyc = 0;
    int    idle_run = 0;
    int    mon_gap_err = 0;
    int    mon_rd_err = 0;
    int    mon_vld_err = 0;

    // Log every access; cyc counts cycles since reset release (cycle 0 = IDLE).
    always @(negedge clk) begin
        if (rst) begin
            cyc      = 0;
            idle_run = 0;
        end else begin
            if (bus.iocs) begin
                mon_t.cyc  = cyc;
                mon_t.rw   = bus.iorw;
                mon_t.addr = bus.ioaddr;
                mon_t.data = databus;
                mon_t.vld  = echo_vld;
                obs_q.push_back(mon_t);
                idle_run = 0;
                if (bus.iorw && databus !== spart_rd) mon_rd_err++;
            end else begin
                idle_run++;
                if (idle_run > 1) mon_gap_err++;
                if (echo_vld !== 1'b0) mon_vld_err++;
            end
            cyc++;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic int find_from(input int from, input logic rw, input logic [1:0] addr);
        for (int i = from; i < obs_q.size(); i++) begin
            if (obs_q[i].rw == rw && obs_q[i].addr == addr) return i;
        end
        return -1;
    endfunction

    task automatic test_reset();
        int          base;
        logic [15:0] d;
        rst = 1'b1; br_cfg = 2'b01; rda = 1'b0; tbr = 1'b0;
        d = div_tab[1];
        step(3);
        @(negedge clk);
        n_tests++;
        if ({bus.iocs, bus.iorw, bus.ioaddr} !== 4'b0100) begin
            n_fail++;
            $display("FAIL reset_bus: got cs/rw/addr %b expected 0100", {bus.iocs, bus.iorw, bus.ioaddr});
        end
        n_tests++;
        if (echo_byte !== 8'h00 || echo_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_echo: got byte %h vld %b expected 00 0", echo_byte, echo_vld);
        end
        step(1);
        base = obs_q.size();
        rst  = 1'b0;
        step(6);
        n_tests++;
        if (obs_q.size() < base + 4) begin
            n_fail++;
            $display("FAIL reset_seq_len: got %0d accesses expected >= 4", obs_q.size() - base);
        end else begin
            n_tests++;
            if (obs_q[base].cyc != 1 || obs_q[base].rw !== 1'b0 || obs_q[base].addr !== 2'b10 || obs_q[base].data !== d[7:0]) begin
                n_fail++;
                $display("FAIL reset_db_low: got cyc %0d rw %b addr %b data %h expected cyc 1 rw 0 addr 10 data %h",
                         obs_q[base].cyc, obs_q[base].rw, obs_q[base].addr, obs_q[base].data, d[7:0]);
            end
            n_tests++;
            if (obs_q[base+1].cyc != 2 || obs_q[base+1].rw !== 1'b0 || obs_q[base+1].addr !== 2'b11 || obs_q[base+1].data !== d[15:8]) begin
                n_fail++;
                $display("FAIL reset_db_high: got cyc %0d rw %b addr %b data %h expected cyc 2 rw 0 addr 11 data %h",
                         obs_q[base+1].cyc, obs_q[base+1].rw, obs_q[base+1].addr, obs_q[base+1].data, d[15:8]);
            end
            n_tests++;
            if (obs_q[base+2].cyc != 3 || obs_q[base+2].rw !== 1'b1 || obs_q[base+2].addr !== 2'b01 ||
                obs_q[base+3].rw !== 1'b1 || obs_q[base+3].addr !== 2'b01) begin
                n_fail++;
                $display("FAIL reset_first_poll: got cyc %0d rw %b addr %b expected cyc 3 status reads",
                         obs_q[base+2].cyc, obs_q[base+2].rw, obs_q[base+2].addr);
            end
        end
    endtask

    task automatic test_echo_random(input int iters);
        for (int it = 0; it < iters; it++) begin
            logic [7:0] b;
            int  d, pre, polls, base, ir, iw, bad;
            bit  ready;
            b     = 8'($urandom);
            d     = $urandom_range(0, 5);
            pre   = $urandom_range(0, 3);
            ready = ($urandom_range(0, 1) == 1);
            status_junk = 6'($urandom);
            tbr = ready; rda = 1'b0;
            step(pre);
            base = obs_q.size(); rx_data = b; rda = 1'b1;
            ir = -1;
            for (int k = 0; k < 40 && ir < 0; k++) begin
                step(1);
                ir = find_from(base, 1'b1, 2'b00);
            end
            rda = 1'b0;
            n_tests++;
            if (ir <= base) begin
                n_fail++;
                $display("FAIL echo_rx_timeout: iter %0d got index %0d expected an RX read after status read", it, ir);
                tbr = 1'b0;
                continue;
            end
            if (!ready) begin
                step(d);
                tbr   = 1'b1;
                polls = d + 1;
            end else begin
                polls = 1;
            end
            iw = -1;
            for (int k = 0; k < 40 && iw < 0; k++) begin
                iw = find_from(ir, 1'b0, 2'b00);
                if (iw < 0) step(1);
            end
            tbr = 1'b0;
            n_tests++;
            if (iw < 0) begin
                n_fail++;
                $display("FAIL echo_tx_timeout: iter %0d got no TX write expected one within 40 cycles", it);
                continue;
            end
            n_tests++;
            if (ir != base + 1) begin
                n_fail++;
                $display("FAIL echo_rx_latency: iter %0d got %0d status reads before RX expected 1", it, ir - base);
            end
            n_tests++;
            if (obs_q[ir].data !== b || obs_q[ir].vld !== 1'b0) begin
                n_fail++;
                $display("FAIL echo_rx_data: iter %0d got %h vld %b expected %h vld 0", it, obs_q[ir].data, obs_q[ir].vld, b);
            end
            bad = 0;
            for (int i = ir + 1; i < iw; i++) begin
                if (obs_q[i].rw !== 1'b1 || obs_q[i].addr !== 2'b01 || obs_q[i].vld !== 1'b0) bad++;
            end
            n_tests++;
            if (iw - ir - 1 != polls || bad != 0) begin
                n_fail++;
                $display("FAIL echo_tx_polls: iter %0d got %0d polls (%0d bad) expected %0d status reads", it, iw - ir - 1, bad, polls);
            end
            n_tests++;
            if (obs_q[iw].cyc - obs_q[ir-1].cyc != polls + 2) begin
                n_fail++;
                $display("FAIL echo_latency: iter %0d got %0d cycles expected %0d", it, obs_q[iw].cyc - obs_q[ir-1].cyc, polls + 2);
            end
            n_tests++;
            if (obs_q[iw].data !== b || obs_q[iw].vld !== 1'b1) begin
                n_fail++;
                $display("FAIL echo_tx_data: iter %0d got %h vld %b expected %h vld 1", it, obs_q[iw].data, obs_q[iw].vld, b);
            end
            n_tests++;
            if (echo_byte !== b) begin
                n_fail++;
                $display("FAIL echo_byte: iter %0d got %h expected %h", it, echo_byte, b);
            end
        end
    endtask

    task automatic test_tbr_stall();
        int base, ir, iw, bad;
        tbr = 1'b0; rda = 1'b0; status_junk = 6'h3F;
        step(2);
        base = obs_q.size(); rx_data = 8'hC3; rda = 1'b1;
        ir = -1;
        for (int k = 0; k < 40 && ir < 0; k++) begin
            step(1);
            ir = find_from(base, 1'b1, 2'b00);
        end
        rda = 1'b0;
        n_tests++;
        if (ir < 0) begin
            n_fail++;
            $display("FAIL stall_rx_timeout: got no RX read expected one within 40 cycles");
            return;
        end
        step(9);
        tbr = 1'b1;
        iw = -1;
        for (int k = 0; k < 40 && iw < 0; k++) begin
            iw = find_from(ir, 1'b0, 2'b00);
            if (iw < 0) step(1);
        end
        tbr = 1'b0;
        n_tests++;
        if (iw < 0) begin
            n_fail++;
            $display("FAIL stall_tx_timeout: got no TX write expected one after TBR");
            return;
        end
        bad = 0;
        for (int i = ir + 1; i < iw; i++) begin
            if (obs_q[i].rw !== 1'b1 || obs_q[i].addr !== 2'b01) bad++;
        end
        n_tests++;
        if (iw - ir - 1 != 10 || bad != 0) begin
            n_fail++;
            $display("FAIL stall_polls: got %0d accesses (%0d not status reads) expected 10 status reads", iw - ir - 1, bad);
        end
        n_tests++;
        if (obs_q[iw].data !== 8'hC3) begin
            n_fail++;
            $display("FAIL stall_tx_data: got %h expected c3", obs_q[iw].data);
        end
    endtask

    task automatic test_reset_mid();
        int          base, ir;
        logic [1:0]  cfg;
        logic [15:0] d;
        tbr = 1'b0; rda = 1'b0;
        step(2);
        base = obs_q.size(); rx_data = 8'($urandom); rda = 1'b1;
        ir = -1;
        for (int k = 0; k < 40 && ir < 0; k++) begin
            step(1);
            ir = find_from(base, 1'b1, 2'b00);
        end
        rda = 1'b0;
        n_tests++;
        if (ir < 0) begin
            n_fail++;
            $display("FAIL rstmid_rx_timeout: got no RX read expected one within 40 cycles");
            return;
        end
        step(2);
        cfg    = 2'($urandom);
        d      = div_tab[cfg];
        br_cfg = cfg;
        rst    = 1'b1;
        step(1);
        @(negedge clk);
        n_tests++;
        if (bus.iocs !== 1'b0 || echo_byte !== 8'h00 || echo_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_release: got cs %b byte %h vld %b expected 0 00 0", bus.iocs, echo_byte, echo_vld);
        end
        step(1);
        base = obs_q.size();
        rst  = 1'b0;
        tbr  = 1'b1;
        step(8);
        tbr  = 1'b0;
        n_tests++;
        if (obs_q.size() < base + 2 || obs_q[base].addr !== 2'b10 || obs_q[base].data !== d[7:0] ||
            obs_q[base+1].addr !== 2'b11 || obs_q[base+1].data !== d[15:8]) begin
            n_fail++;
            $display("FAIL rstmid_reprogram: got %0d accesses, expected divisor %h rewritten for cfg %b",
                     obs_q.size() - base, d, cfg);
        end
        n_tests++;
        if (find_from(base, 1'b0, 2'b00) != -1) begin
            n_fail++;
            $display("FAIL rstmid_stale_tx: got TX write at index %0d expected none", find_from(base, 1'b0, 2'b00));
        end
    endtask

    task automatic test_reconfig();
        int base, ilo;
        rst = 1'b1; br_cfg = 2'b00; rda = 1'b0; tbr = 1'b0;
        step(3);
        base = obs_q.size();
        rst  = 1'b0;
        step(6);
        n_tests++;
        if (obs_q.size() < base + 2 || obs_q[base].data !== 8'h15 || obs_q[base+1].data !== 8'h05) begin
            n_fail++;
            $display("FAIL reconfig_initial: got %0d accesses expected divisor 0515 written", obs_q.size() - base);
        end
        base   = obs_q.size();
        br_cfg = 2'b11;
        step(8);
        ilo = find_from(base, 1'b0, 2'b10);
`ifdef SPART_DRIVER_RECONFIG_EN
        n_tests++;
        if (ilo < 1 || ilo + 1 >= obs_q.size()) begin
            n_fail++;
            $display("FAIL reconfig_rewrite: got index %0d expected DB low rewrite", ilo);
        end else begin
            n_tests++;
            if (obs_q[ilo].data !== 8'hA2 || obs_q[ilo+1].addr !== 2'b11 || obs_q[ilo+1].data !== 8'h00 ||
                obs_q[ilo].cyc - obs_q[ilo-1].cyc != 2) begin
                n_fail++;
                $display("FAIL reconfig_values: got low %h high %h gap %0d expected a2 00 gap 2",
                         obs_q[ilo].data, obs_q[ilo+1].data, obs_q[ilo].cyc - obs_q[ilo-1].cyc);
            end
        end
`else
        n_tests++;
        if (ilo != -1 || find_from(base, 1'b0, 2'b11) != -1) begin
            n_fail++;
            $display("FAIL reconfig_ignored: got divisor rewrite at index %0d expected none", ilo);
        end
`endif
    endtask

    task automatic test_bus_monitor();
        n_tests++;
        if (mon_gap_err !== 0) begin
            n_fail++;
            $display("FAIL bus_idle_gap: got %0d over-long idle runs expected 0", mon_gap_err);
        end
        n_tests++;
        if (mon_rd_err !== 0) begin
            n_fail++;
            $display("FAIL bus_read_contention: got %0d corrupted read cycles expected 0", mon_rd_err);
        end
        n_tests++;
        if (mon_vld_err !== 0) begin
            n_fail++;
            $display("FAIL bus_vld_idle: got %0d echo_vld pulses without access expected 0", mon_vld_err);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_echo_random(12);
        test_tbr_stall();
        test_reset_mid();
        test_reconfig();
        test_bus_monitor();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
